mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the instruction held in the EXE-to-MEM pipeline register and issues the data-memory access over a valid/ready request and valid response interface.
- It stalls the upstream pipeline until the access completes, then loads the MEM-to-WB register: result, destination register and write enable.
- Non-memory instructions pass to WB in one cycle with no stall.
- It sits between the EXE-to-MEM register and the register-file write-back port.

Parameters:
- WIDTH, 32, data/address width.
- TIMEOUT, 16, max cycles spent in REQ+WAIT_RSP before the access is aborted with bus_err (>=2).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ALUResultM  in  WIDTH  ALU result; byte address for loads/stores
- WriteDataM  in  WIDTH  store data
- PCPlus4M  in  WIDTH  link value for JAL/JALR write-back
- RdM  in  5  destination register
- RegWriteM  in  1  instruction writes register file
- ResultSrcM  in  1  1 = result from memory, 0 = ALU
- WDMEM  in  1  store enable
- isLoadM  in  1  load
- WD3SrcM  in  1  1 = result is PCPlus4M (overrides ResultSrcM)
- stall_o  out  1  upstream EXE-to-MEM register must HOLD its contents (not insert a bubble) while high
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  WIDTH  word-aligned byte address
- mem_wdata  out  WIDTH  write data
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  WIDTH  read data
- ResultW  out  WIDTH  write-back value
- RdW  out  5  write-back destination
- RegWriteW  out  1  write-back enable
- misaligned_o  out  1  one-cycle pulse, misaligned access dropped
- bus_err_o  out  1  one-cycle pulse, access timed out

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; timeout counter 0; internal latches 0. Reset mid-access abandons the access; mem_req_valid drops immediately.
- access = isLoadM | WDMEM. If both are set, treat as load.
- stall_o is combinational: (IDLE & access & aligned) | REQ | WAIT_RSP.
- IDLE:
  - Not access: WB regs load on the next edge. ResultW = WD3SrcM ? PCPlus4M : ALUResultM. RdW = RdM. RegWriteW = RegWriteM & (RdM != 0).
  - Access with ALUResultM[1:0] != 0: no request. misaligned_o pulses. WB regs load with RegWriteW=0. Stay in IDLE.
  - Aligned access: latch addr, wdata, we=~isLoadM. Go to REQ. RegWriteW <= 0 (bubble).
- REQ:
  - mem_req_valid=1; addr/wdata/we are stable and come from the latches.
  - On mem_req_ready: a store goes to DONE, a load goes to WAIT_RSP.
  - mem_req_valid stays high until accepted and must not drop.
- WAIT_RSP:
  - mem_rsp_valid captures mem_rdata and goes to DONE.
  - The response is never accepted in the same cycle as the request handshake.
  - mem_rsp_valid while in IDLE or REQ is ignored.
- DONE:
  - stall_o=0. WB regs load: ResultW = WD3SrcM ? PCPlus4M : (ResultSrcM ? captured rdata : ALUResultM).
  - RegWriteW = RegWriteM & (RdM != 0) & ~err. Next state IDLE.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/WAIT_RSP.
  - On reaching TIMEOUT-1 without completion: go to DONE with err=1, bus_err_o pulses in DONE, mem_req_valid drops.
  - A response arriving after abort is ignored.
- RegWriteW is 0 in every cycle WB is not loaded with a completed instruction.
- Latency:
  - Non-access: 1 cycle.
  - Store with ready=1: IDLE, REQ, DONE; WB valid after the 3rd edge, 2 stall cycles.
  - Load, ready=1, response the next cycle: 4 edges, 3 stall cycles.

Test Plan:
- ADD, ALUResultM=0x55, RdM=5, RegWriteM=1 -> next edge ResultW=0x55, RdW=5, RegWriteW=1, stall_o never high.
- Load addr 0x100, ready=1, rsp next cycle with rdata=0xDEADBEEF, ResultSrcM=1, RdM=7 -> mem_addr=0x100, mem_we=0; stall_o high 3 cycles; then ResultW=0xDEADBEEF, RegWriteW=1.
- Store addr 0x40, data 0x1234, ready held low 3 cycles -> mem_req_valid/addr/wdata stable for 4 cycles, mem_we=1; DONE follows; RegWriteW=0.
- Load addr 0x102 -> no mem_req_valid, misaligned_o pulses once, RegWriteW=0, stall_o=0.
- Load with ready=0 forever, TIMEOUT=16 -> abort after 16 cycles in REQ, bus_err_o pulses, RegWriteW=0, state returns to IDLE.
- rst_n low while in WAIT_RSP -> all outputs 0 immediately; a later mem_rsp_valid causes no write-back; JAL with WD3SrcM=1, PCPlus4M=0x2004, RdM=1 -> ResultW=0x2004.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bundle between the memory-stage LSU (master)
// and the data memory (slave).
interface mem_stage_lsu_if #(
    parameter int WIDTH = 32
);
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_rsp_valid;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues the data-memory access for the instruction
// in the EXE-to-MEM register, stalls upstream until done, and loads the MEM-to-WB register.
module mem_stage_lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             ResultSrcM,
    input  logic             WDMEM,
    input  logic             isLoadM,
    input  logic             WD3SrcM,
    output logic             stall_o,
    mem_stage_lsu_if.master  mem,
    output logic [WIDTH-1:0] ResultW,
    output logic [4:0]       RdW,
    output logic             RegWriteW,
    output logic             misaligned_o,
    output logic             bus_err_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam int             CW   = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  TLIM = CW'(TIMEOUT - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-3:0] addr_r;
    logic [WIDTH-1:0] wdata_r;
    logic             we_r;
    logic [WIDTH-1:0] rdata_r;
    logic             err_r;
    logic [WIDTH-1:0] result_r;
    logic [4:0]       rd_r;
    logic             regwrite_r;
    logic             misaligned_r;
    logic             bus_err_r;

    logic             access_s;
    logic             aligned_s;
    logic             timeout_s;
    logic             abort_s;
    logic             wb_we_s;
    logic [WIDTH-1:0] wb_result_s;

    assign access_s  = isLoadM | WDMEM;
    assign aligned_s = (ALUResultM[1:0] == 2'b00);
    assign timeout_s = (cnt_r >= TLIM);
    assign wb_we_s   = RegWriteM & (RdM != 5'd0);

    // Write-back value; captured read data is only meaningful once the access has completed
    always_comb begin
        wb_result_s = ALUResultM;
        if (WD3SrcM) begin
            wb_result_s = PCPlus4M;
        end else if (ResultSrcM && (state_r == DONE)) begin
            wb_result_s = rdata_r;
        end else begin
            wb_result_s = ALUResultM;
        end
    end

    // Next-state logic; a handshake in the final allowed cycle still wins over the abort
    always_comb begin
        state_nxt_s = state_r;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s && aligned_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_nxt_s = we_r ? DONE : WAIT_RSP;
                end else if (timeout_s) begin
                    state_nxt_s = DONE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT_RSP: begin
                if (mem.mem_rsp_valid) begin
                    state_nxt_s = DONE;
                end else if (timeout_s) begin
                    state_nxt_s = DONE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, access latches, timeout counter and MEM-to-WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            addr_r       <= '0;
            wdata_r      <= '0;
            we_r         <= 1'b0;
            rdata_r      <= '0;
            err_r        <= 1'b0;
            result_r     <= '0;
            rd_r         <= 5'd0;
            regwrite_r   <= 1'b0;
            misaligned_r <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            misaligned_r <= 1'b0;
            bus_err_r    <= abort_s;
            case (state_r)
                IDLE: begin
                    if (!access_s) begin
                        result_r   <= wb_result_s;
                        rd_r       <= RdM;
                        regwrite_r <= wb_we_s;
                    end else if (!aligned_s) begin
                        misaligned_r <= 1'b1;
                        result_r     <= wb_result_s;
                        rd_r         <= RdM;
                        regwrite_r   <= 1'b0;
                    end else begin
                        addr_r     <= ALUResultM[WIDTH-1:2];
                        wdata_r    <= WriteDataM;
                        we_r       <= ~isLoadM;
                        err_r      <= 1'b0;
                        cnt_r      <= '0;
                        regwrite_r <= 1'b0;
                    end
                end
                REQ: begin
                    regwrite_r <= 1'b0;
                    cnt_r      <= cnt_r + CW'(1);
                    err_r      <= abort_s;
                end
                WAIT_RSP: begin
                    regwrite_r <= 1'b0;
                    cnt_r      <= cnt_r + CW'(1);
                    err_r      <= abort_s;
                    if (mem.mem_rsp_valid) begin
                        rdata_r <= mem.mem_rdata;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                DONE: begin
                    result_r   <= wb_result_s;
                    rd_r       <= RdM;
                    regwrite_r <= wb_we_s & ~err_r;
                end
                default: begin
                    regwrite_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o = rst_n & (((state_r == IDLE) & access_s & aligned_s) |
                              (state_r == REQ) | (state_r == WAIT_RSP));

    assign mem.mem_req_valid = (state_r == REQ);
    assign mem.mem_we        = we_r;
    assign mem.mem_addr      = {addr_r, 2'b00};
    assign mem.mem_wdata     = wdata_r;

    assign ResultW      = result_r;
    assign RdW          = rd_r;
    assign RegWriteW    = regwrite_r;
    assign misaligned_o = misaligned_r;
    assign bus_err_o    = bus_err_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: ALU pass-through, load, store with backpressure,
// misaligned drop, timeout abort, reset mid-access and JAL link write-back.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        ResultSrcM;
    logic        WDMEM;
    logic        isLoadM;
    logic        WD3SrcM;
    logic        stall_o;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        misaligned_o;
    logic        bus_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu_if #(.WIDTH(32)) bus ();

    mem_stage_lsu #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .PCPlus4M     (PCPlus4M),
        .RdM          (RdM),
        .RegWriteM    (RegWriteM),
        .ResultSrcM   (ResultSrcM),
        .WDMEM        (WDMEM),
        .isLoadM      (isLoadM),
        .WD3SrcM      (WD3SrcM),
        .stall_o      (stall_o),
        .mem          (bus.master),
        .ResultW      (ResultW),
        .RdW          (RdW),
        .RegWriteW    (RegWriteW),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        PCPlus4M   = 32'h0;
        RdM        = 5'd0;
        RegWriteM  = 1'b0;
        ResultSrcM = 1'b0;
        WDMEM      = 1'b0;
        isLoadM    = 1'b0;
        WD3SrcM    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;
        #1;
        chk("rst_result", ResultW, 32'h0);
        chk("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ALU instruction passes straight through
        ALUResultM = 32'h55; RdM = 5'd5; RegWriteM = 1'b1;
        #1;
        chk("add_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("add_result", ResultW, 32'h55);
        chk("add_rd", {27'd0, RdW}, 32'd5);
        chk("add_regwrite", {31'd0, RegWriteW}, 32'd1);
        RdM = 5'd0; ALUResultM = 32'h99;
        tick();
        chk("x0_regwrite", {31'd0, RegWriteW}, 32'd0);
        nop();
        tick();

        // Load, ready high, response one cycle after acceptance
        ALUResultM = 32'h100; isLoadM = 1'b1; ResultSrcM = 1'b1; RdM = 5'd7; RegWriteM = 1'b1;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("ld_stall_idle", {31'd0, stall_o}, 32'd1);
        tick();
        chk("ld_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("ld_addr", bus.mem_addr, 32'h100);
        chk("ld_we", {31'd0, bus.mem_we}, 32'd0);
        chk("ld_stall_req", {31'd0, stall_o}, 32'd1);
        chk("ld_bubble", {31'd0, RegWriteW}, 32'd0);
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hDEADBEEF;
        #1;
        chk("ld_stall_wait", {31'd0, stall_o}, 32'd1);
        chk("ld_valid_dropped", {31'd0, bus.mem_req_valid}, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;
        #1;
        chk("ld_stall_done", {31'd0, stall_o}, 32'd0);
        chk("ld_done_bubble", {31'd0, RegWriteW}, 32'd0);
        tick();
        chk("ld_result", ResultW, 32'hDEADBEEF);
        chk("ld_rd", {27'd0, RdW}, 32'd7);
        chk("ld_regwrite", {31'd0, RegWriteW}, 32'd1);
        nop();
        tick();

        // Store with three cycles of backpressure
        ALUResultM = 32'h40; WriteDataM = 32'h1234; WDMEM = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_req_ready = 1'b1;
            #1;
            chk("st_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
            chk("st_addr", bus.mem_addr, 32'h40);
            chk("st_wdata", bus.mem_wdata, 32'h1234);
            chk("st_we", {31'd0, bus.mem_we}, 32'd1);
            tick();
        end
        bus.mem_req_ready = 1'b0;
        #1;
        chk("st_done_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("st_done_stall", {31'd0, stall_o}, 32'd0);
        chk("st_done_buserr", {31'd0, bus_err_o}, 32'd0);
        tick();
        chk("st_regwrite", {31'd0, RegWriteW}, 32'd0);
        nop();
        tick();

        // Misaligned load is dropped
        ALUResultM = 32'h102; isLoadM = 1'b1; ResultSrcM = 1'b1; RdM = 5'd4; RegWriteM = 1'b1;
        #1;
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, misaligned_o}, 32'd1);
        chk("mis_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("mis_regwrite", {31'd0, RegWriteW}, 32'd0);
        nop();
        tick();
        chk("mis_pulse_end", {31'd0, misaligned_o}, 32'd0);

        // Load that is never accepted times out
        ALUResultM = 32'h200; isLoadM = 1'b1; ResultSrcM = 1'b1; RdM = 5'd9; RegWriteM = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
            chk("to_no_err", {31'd0, bus_err_o}, 32'd0);
            tick();
        end
        chk("to_bus_err", {31'd0, bus_err_o}, 32'd1);
        chk("to_valid_dropped", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("to_stall", {31'd0, stall_o}, 32'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hBAD;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("to_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("to_err_end", {31'd0, bus_err_o}, 32'd0);
        nop();
        #1;
        chk("to_idle_stall", {31'd0, stall_o}, 32'd0);
        tick();

        // Reset while waiting for a read response
        ALUResultM = 32'h300; isLoadM = 1'b1; ResultSrcM = 1'b1; RdM = 5'd2; RegWriteM = 1'b1;
        bus.mem_req_ready = 1'b1;
        tick();
        tick();
        bus.mem_req_ready = 1'b0;
        chk("rw_stall_wait", {31'd0, stall_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("rw_stall", {31'd0, stall_o}, 32'd0);
        chk("rw_result", ResultW, 32'h0);
        chk("rw_regwrite", {31'd0, RegWriteW}, 32'd0);
        nop();
        tick();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h77;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("rw_late_rsp", {31'd0, RegWriteW}, 32'd0);
        chk("rw_late_stall", {31'd0, stall_o}, 32'd0);

        // JAL link value overrides the ALU result
        ALUResultM = 32'h3000; PCPlus4M = 32'h2004; WD3SrcM = 1'b1; RdM = 5'd1; RegWriteM = 1'b1;
        tick();
        chk("jal_result", ResultW, 32'h2004);
        chk("jal_rd", {27'd0, RdW}, 32'd1);
        chk("jal_regwrite", {31'd0, RegWriteW}, 32'd1);
        nop();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
